// File: rtl/shift_reg_ctrl_pkg.sv
// Shared encodings for shift_reg_ctrl: register-control modes, FSM states, widths.
// SHREG_CTRL_PARITY_EN adds the PARITY state to the state set.
package shift_reg_ctrl_pkg;

   localparam int unsigned DataW = 4;
   localparam int unsigned CntW  = 2;

   typedef enum logic [1:0] {
      ModeShift = 2'b00,
      ModeLoad  = 2'b10,
      ModeHold  = 2'b11
   } modo_e;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StLoad   = 3'd1,
      StShift  = 3'd2,
`ifdef SHREG_CTRL_PARITY_EN
      StFin    = 3'd3,
      StParity = 3'd4
`else
      StFin    = 3'd3
`endif
   } state_e;

   function automatic logic even_parity(input logic [DataW-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// Data-bit counter for shift_reg_ctrl: counts 0..3 while enabled, clears otherwise.
module tx_bit_counter
   import shift_reg_ctrl_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_tc
);

   logic [CntW-1:0] r_cnt;

   // Wraps 3->0 on the last bit, so leaving SHIFT always finds the counter cleared.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

   assign o_tc = &r_cnt;

endmodule

// File: rtl/shift_reg_ctrl.sv
// Frame controller driving an external 4-bit shift register onto a serial TX line.
// Define SHREG_CTRL_PARITY_EN to append an even-parity bit to each frame.
module shift_reg_ctrl
   import shift_reg_ctrl_pkg::*;
(
   input  logic             CLK,
   input  logic             RESET_L,
   input  logic [DataW-1:0] DATA_IN,
   input  logic             VALID,
   input  logic             DIR_SEL,
   output logic             READY,
   output logic             ENB,
   output logic             DIR,
   output logic [1:0]       MODO,
   output logic [DataW-1:0] D,
   output logic             S_IN,
   input  logic             S_OUT,
   output logic             TX,
   output logic             TX_VALID,
   output logic             DONE
);

   state_e           r_state;
   state_e           w_state_next;
   logic [DataW-1:0] r_word;
   logic             r_dir;
   logic             w_accept;
   logic             w_in_shift;
   logic             w_tc;
`ifdef SHREG_CTRL_PARITY_EN
   logic             r_par;
`endif

   assign w_accept   = (r_state == StIdle) && VALID;
   assign w_in_shift = (r_state == StShift);

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Word, direction and parity are frozen at accept; later input changes are ignored.
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         r_word <= '0;
         r_dir  <= 1'b0;
`ifdef SHREG_CTRL_PARITY_EN
         r_par  <= 1'b0;
`endif
      end else if (w_accept) begin
         r_word <= DATA_IN;
         r_dir  <= DIR_SEL;
`ifdef SHREG_CTRL_PARITY_EN
         r_par  <= even_parity(DATA_IN);
`endif
      end
   end

   tx_bit_counter u_bit_cnt (
      .i_clk   (CLK),
      .i_rst_n (RESET_L),
      .i_en    (w_in_shift),
      .o_tc    (w_tc)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:   if (VALID) w_state_next = StLoad;
         StLoad:   w_state_next = StShift;
         StShift: begin
            if (w_tc) begin
`ifdef SHREG_CTRL_PARITY_EN
               w_state_next = StParity;
`else
               w_state_next = StFin;
`endif
            end
         end
`ifdef SHREG_CTRL_PARITY_EN
         StParity: w_state_next = StFin;
`endif
         StFin:    w_state_next = StIdle;
         default:  w_state_next = StIdle;
      endcase
   end

   always_comb begin
      READY    = 1'b0;
      ENB      = 1'b0;
      DIR      = 1'b0;
      MODO     = ModeHold;
      D        = '0;
      S_IN     = 1'b0;
      TX       = 1'b1;
      TX_VALID = 1'b0;
      DONE     = 1'b0;
      case (r_state)
         StIdle: READY = 1'b1;
         StLoad: begin
            ENB  = 1'b1;
            MODO = ModeLoad;
            D    = r_word;
            DIR  = r_dir;
         end
         StShift: begin
            ENB      = 1'b1;
            MODO     = ModeShift;
            DIR      = r_dir;
            TX_VALID = 1'b1;
            TX       = S_OUT;
         end
`ifdef SHREG_CTRL_PARITY_EN
         StParity: begin
            TX_VALID = 1'b1;
            TX       = r_par;
         end
`endif
         StFin:   DONE = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl: frame-position reference model, per-cycle compare, directed cases.
// Honours SHREG_CTRL_PARITY_EN the same way the design does.
module tb_shift_reg_ctrl;

`ifdef SHREG_CTRL_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FLEN = 6 + PAR;  // frame cycles: LOAD, 4 data bits, [parity], FIN

   logic       CLK = 1'b0;
   logic       RESET_L = 1'b0;
   logic [3:0] DATA_IN = '0;
   logic       VALID = 1'b0;
   logic       DIR_SEL = 1'b0;
   logic       READY, ENB, DIR, S_IN, S_OUT, TX, TX_VALID, DONE;
   logic [1:0] MODO;
   logic [3:0] D;

   int n_checks = 0;
   int n_err = 0;

   shift_reg_ctrl dut (
      .CLK      (CLK),
      .RESET_L  (RESET_L),
      .DATA_IN  (DATA_IN),
      .VALID    (VALID),
      .DIR_SEL  (DIR_SEL),
      .READY    (READY),
      .ENB      (ENB),
      .DIR      (DIR),
      .MODO     (MODO),
      .D        (D),
      .S_IN     (S_IN),
      .S_OUT    (S_OUT),
      .TX       (TX),
      .TX_VALID (TX_VALID),
      .DONE     (DONE)
   );

   initial forever #5 CLK = ~CLK;

   // External 4-bit shift register the controller drives.
   logic [3:0] sr_q = '0;
   always @(posedge CLK) begin
      if (ENB) begin
         if (MODO == 2'b10)      sr_q <= D;
         else if (MODO == 2'b00) sr_q <= DIR ? {S_IN, sr_q[3:1]} : {sr_q[2:0], S_IN};
      end
   end
   assign S_OUT = DIR ? sr_q[0] : sr_q[3];

   // Reference model: position within the current frame (0 = idle).
   int         m_pos = 0;
   logic [3:0] m_word = '0;
   logic       m_dir = 1'b0;
   always @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         m_pos  <= 0;
         m_word <= '0;
         m_dir  <= 1'b0;
      end else if (m_pos == 0) begin
         if (VALID) begin
            m_pos  <= 1;
            m_word <= DATA_IN;
            m_dir  <= DIR_SEL;
         end
      end else if (m_pos == FLEN) begin
         m_pos <= 0;
      end else begin
         m_pos <= m_pos + 1;
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [7:0] frame_exp(input logic [3:0] bits, input logic p);
      return (PAR == 1) ? {3'b000, bits, p} : {4'h0, bits};
   endfunction

   // Per-cycle compare against the model, plus frame capture.
   logic [7:0] cap = '0;
   logic [7:0] last_cap = '0;
   int ncap = 0, last_n = 0, done_cnt = 0, ready_run = 0, last_gap = 0;
   initial begin
      logic e_tx, e_enb;
      logic [1:0] e_modo;
      int k;
      forever begin
         @(negedge CLK);
         k      = m_pos - 2;
         e_enb  = (m_pos >= 1 && m_pos <= 5);
         e_modo = (m_pos == 1) ? 2'b10 : (m_pos >= 2 && m_pos <= 5) ? 2'b00 : 2'b11;
         if (m_pos >= 2 && m_pos <= 5)    e_tx = m_dir ? m_word[k] : m_word[3-k];
         else if (PAR == 1 && m_pos == 6) e_tx = ^m_word;
         else                             e_tx = 1'b1;
         chk("ready", {7'd0, READY}, {7'd0, m_pos == 0});
         chk("enb", {7'd0, ENB}, {7'd0, e_enb});
         chk("modo", {6'd0, MODO}, {6'd0, e_modo});
         chk("tx", {7'd0, TX}, {7'd0, e_tx});
         chk("tx_valid", {7'd0, TX_VALID}, {7'd0, m_pos >= 2 && m_pos <= 5 + PAR});
         chk("done", {7'd0, DONE}, {7'd0, m_pos == FLEN});
         chk("s_in", {7'd0, S_IN}, 8'd0);
         if (m_pos == 1) chk("load_d", {4'd0, D}, {4'd0, m_word});
         if (m_pos >= 1 && m_pos <= 5) chk("dir", {7'd0, DIR}, {7'd0, m_dir});
         if (!RESET_L) begin
            chk("rst_d", {4'd0, D}, 8'd0);
            chk("rst_dir", {7'd0, DIR}, 8'd0);
            cap  = '0;
            ncap = 0;
         end else begin
            if (TX_VALID) begin
               cap = {cap[6:0], TX};
               ncap++;
            end
            if (READY) ready_run++;
            if (DONE) begin
               last_cap  = cap;
               last_n    = ncap;
               last_gap  = ready_run;
               done_cnt++;
               ready_run = 0;
               cap       = '0;
               ncap      = 0;
            end
         end
      end
   end

   task automatic reset_chk(input string tag);
      chk({tag, "_ready"}, {7'd0, READY}, 8'd1);
      chk({tag, "_enb"}, {7'd0, ENB}, 8'd0);
      chk({tag, "_dir"}, {7'd0, DIR}, 8'd0);
      chk({tag, "_modo"}, {6'd0, MODO}, 8'd3);
      chk({tag, "_d"}, {4'd0, D}, 8'd0);
      chk({tag, "_tx"}, {7'd0, TX}, 8'd1);
      chk({tag, "_txv"}, {7'd0, TX_VALID}, 8'd0);
      chk({tag, "_done"}, {7'd0, DONE}, 8'd0);
   endtask

   task automatic send(input logic [3:0] w, input logic dir);
      @(posedge CLK); #2;
      VALID = 1'b1; DATA_IN = w; DIR_SEL = dir;
      @(posedge CLK); #2;
      VALID = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int d0 = done_cnt;
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge CLK);
         if (done_cnt > d0) seen = 1;
      end
      if (!seen) begin
         n_checks++;
         n_err++;
         $display("FAIL %s timeout: got no DONE expected DONE within 40 cycles", tag);
      end
   endtask

   task automatic chk_frame(input string tag, input logic [7:0] exp);
      chk({tag, "_bits"}, last_cap, exp);
      chk({tag, "_len"}, 8'(last_n), 8'(4 + PAR));
   endtask

   initial begin
      int d0;
      #12 reset_chk("por");
      @(posedge CLK); #3 RESET_L = 1'b1;

      send(4'b1011, 1'b0);
      wait_done("msb");
      chk_frame("msb_1011", frame_exp(4'b1011, 1'b1));

      send(4'b1011, 1'b1);
      wait_done("lsb");
      chk_frame("lsb_1011", frame_exp(4'b1101, 1'b1));

      // VALID held high across two frames.
      @(posedge CLK); #2;
      VALID = 1'b1; DATA_IN = 4'hA; DIR_SEL = 1'b0;
      @(posedge CLK); #2;
      DATA_IN = 4'h5;
      wait_done("b2b_a");
      chk_frame("b2b_a", frame_exp(4'hA, 1'b0));
      @(posedge CLK); #2;
      VALID = 1'b0;
      wait_done("b2b_5");
      chk_frame("b2b_5", frame_exp(4'h5, 1'b0));
      chk("b2b_gap", 8'(last_gap), 8'd1);

      // Input changes during the frame must not leak in.
      send(4'h3, 1'b0);
      @(posedge CLK); #2;
      DATA_IN = 4'hC; DIR_SEL = 1'b1;
      wait_done("hold3");
      chk_frame("hold3", frame_exp(4'h3, 1'b0));

      // Reset in the second SHIFT cycle, then accept 4'hF right after release.
      send(4'h6, 1'b1);
      @(posedge CLK);
      @(posedge CLK); #2;
      d0 = done_cnt;
      RESET_L = 1'b0;
      VALID = 1'b1; DATA_IN = 4'hF; DIR_SEL = 1'b0;
      #1 reset_chk("mid");
      @(posedge CLK); #3 RESET_L = 1'b1;
      @(posedge CLK); #2 VALID = 1'b0;
      wait_done("after_rst");
      chk("abort_no_done", 8'(done_cnt - d0), 8'd1);
      chk_frame("rst_f", frame_exp(4'hF, 1'b0));

      // Random traffic; VALID and data toggle freely, including mid-frame.
      d0 = done_cnt;
      for (int i = 0; i < 400; i++) begin
         @(posedge CLK); #2;
         VALID   = ($urandom_range(0, 2) == 0);
         DATA_IN = 4'($urandom);
         DIR_SEL = 1'($urandom);
      end
      VALID = 1'b0;
      repeat (FLEN + 3) @(posedge CLK);
      n_checks++;
      if (done_cnt - d0 < 10) begin
         n_err++;
         $display("FAIL rand_frames: got %0d frames expected at least 10", done_cnt - d0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

endmodule
